// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Data-memory access stage for the multicycle core. Accepts one load/store
// request, checks width legality and alignment, runs a single valid/ready
// transaction with byte strobes, and returns an extended load result.
// Illegal widths, misaligned addresses and timeouts end in a fault pulse.
//
// Ports
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_req/i_we/i_funct3  request strobe, store select, width/sign code
//   i_addr/i_wdata       byte address, low-aligned store data
//   o_busy               high outside IDLE
//   o_done/o_fault       one-cycle completion pulse, fault flag with it
//   o_fault_code         01 misaligned, 10 illegal funct3, 11 timeout
//   o_rdata              extended load result, held until the next load
//   o_mem_*/i_mem_*      valid/ready memory port (word address, strobes)
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic [1:0]  o_fault_code,
   output logic [31:0] o_rdata,
   output logic        o_mem_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_wstrb,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_next;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [1:0]  r_a10;
   logic [7:0]  r_cnt;
   logic [1:0]  r_code;
   logic [31:0] r_rdata;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;

   logic        w_bad_f3, w_misal;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic        w_hs;

   // Legality of the incoming request (only meaningful in IDLE with i_req)
   always_comb begin
      w_bad_f3 = 1'b0;
      if (i_we)
         w_bad_f3 = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010);
      else
         w_bad_f3 = (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
      w_misal = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
   end

   // Store lane placement; loads never drive strobes
   always_comb begin
      w_strb  = 4'b0000;
      w_wdata = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            w_strb  = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_strb  = 4'b0011 << i_addr[1:0];
            w_wdata = {2{i_wdata[15:0]}};
         end
         default: w_strb = 4'b1111;
      endcase
      if (!i_we) w_strb = 4'b0000;
   end

   // Load lane extraction from the latched offset and width
   always_comb begin
      case (r_a10)
         2'd0:    w_byte = i_mem_rdata[7:0];
         2'd1:    w_byte = i_mem_rdata[15:8];
         2'd2:    w_byte = i_mem_rdata[23:16];
         default: w_byte = i_mem_rdata[31:24];
      endcase
      w_half = r_a10[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (r_f3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_ext = {24'h0, w_byte};
         3'b101:  w_ext = {16'h0, w_half};
         default: w_ext = i_mem_rdata;
      endcase
   end

   assign w_hs = (r_state == ACCESS) && i_mem_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (i_req) w_next = (w_bad_f3 || w_misal) ? FAULT : ACCESS;
         ACCESS: begin
            // ready on the final wait cycle still completes the access
            if (i_mem_ready)             w_next = DONE;
            else if (r_cnt == TMO_LAST)  w_next = FAULT;
         end
         DONE:    w_next = IDLE;
         FAULT:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_f3       <= 3'b000;
         r_a10      <= 2'b00;
         r_cnt      <= 8'd0;
         r_code     <= 2'b00;
         r_rdata    <= 32'h0;
         r_mem_addr <= 32'h0;
         r_wstrb    <= 4'b0000;
         r_wdata    <= 32'h0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               r_cnt <= 8'd0;
               if (i_req) begin
                  r_we  <= i_we;
                  r_f3  <= i_funct3;
                  r_a10 <= i_addr[1:0];
                  if (w_bad_f3)     r_code <= 2'b10;
                  else if (w_misal) r_code <= 2'b01;
                  else begin
                     // memory port only updated for accesses that will issue
                     r_mem_addr <= {i_addr[31:2], 2'b00};
                     r_wstrb    <= w_strb;
                     r_wdata    <= w_wdata;
                  end
               end
            end
            ACCESS: begin
               if (w_hs) begin
                  if (!r_we) r_rdata <= w_ext;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == TMO_LAST) r_code <= 2'b11;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == DONE) || (r_state == FAULT);
   assign o_fault      = (r_state == FAULT);
   assign o_fault_code = r_code;
   assign o_rdata      = r_rdata;
   assign o_mem_valid  = (r_state == ACCESS);
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wstrb  = r_wstrb;
   assign o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit (TIMEOUT=4). Inputs change on the falling
// edge, outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req = 1'b0, we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        busy, done, fault;
   logic [1:0]  fault_code;
   logic [31:0] rdata;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_funct3(funct3),
      .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
      .o_fault(fault), .o_fault_code(fault_code), .o_rdata(rdata),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
      .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Presents a request for one cycle; returns at the falling edge of cycle 1
   task automatic start(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      req = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, fault, mem_valid} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {busy, done, fault, mem_valid});
      end
      n_cmp++;
      if ({fault_code, mem_wstrb} !== 6'b0) begin
         n_err++; $display("FAIL reset_code_strb got %b want 000000", {fault_code, mem_wstrb});
      end
      n_cmp++;
      if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin
         n_err++; $display("FAIL reset_data got %h %h %h want zeros", rdata, mem_addr, mem_wdata);
      end
      reset = 1'b0;
   endtask

   task automatic test_load_word();
      start(1'b0, 3'b010, 32'h100, 32'h0);
      n_cmp++;
      if ({mem_valid, busy, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 32'h100, 4'b0000}) begin
         n_err++; $display("FAIL lw_issue got v=%b b=%b a=%h s=%b want v=1 b=1 a=00000100 s=0000",
                           mem_valid, busy, mem_addr, mem_wstrb);
      end
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if ({done, fault, mem_valid, rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL lw_done got d=%b f=%b v=%b r=%h want d=1 f=0 v=0 r=deadbeef",
                           done, fault, mem_valid, rdata);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++; $display("FAIL lw_idle got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  t_f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] t_a  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
      logic [31:0] t_x  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
      for (int i = 0; i < 4; i++) begin
         start(1'b0, t_f3[i], t_a[i], 32'h0);
         mem_ready = 1'b1; mem_rdata = 32'h80FF1234;
         @(negedge clk);
         mem_ready = 1'b0; mem_rdata = 32'h0;
         n_cmp++;
         if ({done, fault, rdata} !== {1'b1, 1'b0, t_x[i]}) begin
            n_err++; $display("FAIL load_ext[%0d] got d=%b f=%b r=%h want d=1 f=0 r=%h",
                              i, done, fault, rdata, t_x[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_store();
      logic [2:0]  t_f3 [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] t_a  [3] = '{32'h201, 32'h202, 32'h204};
      logic [31:0] t_wd [3] = '{32'h000000AB, 32'h00001234, 32'hCAFEF00D};
      logic [31:0] t_ma [3] = '{32'h200, 32'h200, 32'h204};
      logic [3:0]  t_s  [3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] t_md [3] = '{32'hABABABAB, 32'h12341234, 32'hCAFEF00D};
      for (int i = 0; i < 3; i++) begin
         start(1'b1, t_f3[i], t_a[i], t_wd[i]);
         n_cmp++;
         if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, t_ma[i], t_s[i], t_md[i]}) begin
            n_err++; $display("FAIL store[%0d] got v=%b a=%h s=%b d=%h want v=1 a=%h s=%b d=%h",
                              i, mem_valid, mem_addr, mem_wstrb, mem_wdata, t_ma[i], t_s[i], t_md[i]);
         end
         mem_ready = 1'b1; mem_rdata = 32'h55555555;
         @(negedge clk);
         mem_ready = 1'b0; mem_rdata = 32'h0;
         // last load returned 0x000080FF; a store must leave it alone
         n_cmp++;
         if ({done, fault, rdata} !== {1'b1, 1'b0, 32'h000080FF}) begin
            n_err++; $display("FAIL store_done[%0d] got d=%b f=%b r=%h want d=1 f=0 r=000080ff",
                              i, done, fault, rdata);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_decode_fault();
      logic        t_we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  t_f3 [4] = '{3'b010, 3'b100, 3'b101, 3'b111};
      logic [31:0] t_a  [4] = '{32'h102, 32'h100, 32'h101, 32'h101};
      logic [1:0]  t_c  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
         start(t_we[i], t_f3[i], t_a[i], 32'h11111111);
         n_cmp++;
         if ({done, fault, fault_code, mem_valid, rdata} !==
             {1'b1, 1'b1, t_c[i], 1'b0, 32'h000080FF}) begin
            n_err++; $display("FAIL dec_fault[%0d] got d=%b f=%b c=%b v=%b r=%h want d=1 f=1 c=%b v=0 r=000080ff",
                              i, done, fault, fault_code, mem_valid, rdata, t_c[i]);
         end
         @(negedge clk);
         n_cmp++;
         if ({busy, done, mem_valid} !== 3'b000) begin
            n_err++; $display("FAIL dec_idle[%0d] got b=%b d=%b v=%b want 000", i, busy, done, mem_valid);
         end
      end
   endtask

   task automatic test_timeout();
      int vcnt = 0;
      start(1'b0, 3'b010, 32'h300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (mem_valid === 1'b1 && done === 1'b0) vcnt++;
         @(negedge clk);
      end
      n_cmp++;
      if (vcnt !== 4) begin
         n_err++; $display("FAIL tmo_valid_cycles got %0d want 4", vcnt);
      end
      n_cmp++;
      if ({done, fault, fault_code, mem_valid} !== {1'b1, 1'b1, 2'b11, 1'b0}) begin
         n_err++; $display("FAIL tmo_fault got d=%b f=%b c=%b v=%b want d=1 f=1 c=11 v=0",
                           done, fault, fault_code, mem_valid);
      end
      @(negedge clk);
      // ready on the last permitted wait cycle wins over the timeout
      start(1'b0, 3'b000, 32'h301, 32'h0);
      repeat (3) @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'h00007F00;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if ({done, fault, rdata} !== {1'b1, 1'b0, 32'h0000007F}) begin
         n_err++; $display("FAIL tmo_ready_last got d=%b f=%b r=%h want d=1 f=0 r=0000007f",
                           done, fault, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      // request presented while busy must be ignored
      start(1'b0, 3'b010, 32'h400, 32'h0);
      req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h500;
      @(negedge clk);
      req = 1'b0;
      n_cmp++;
      if ({mem_valid, mem_addr, mem_wstrb} !== {1'b1, 32'h400, 4'b0000}) begin
         n_err++; $display("FAIL busy_ignore got v=%b a=%h s=%b want v=1 a=00000400 s=0000",
                           mem_valid, mem_addr, mem_wstrb);
      end
      mem_ready = 1'b1; mem_rdata = 32'h01234567;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, rdata} !== {1'b0, 32'h01234567}) begin
         n_err++; $display("FAIL busy_ignore_end got b=%b r=%h want b=0 r=01234567", busy, rdata);
      end
   endtask

   task automatic test_reset_inflight();
      int dcnt = 0;
      start(1'b0, 3'b010, 32'h600, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({mem_valid, busy, done} !== 3'b000) begin
         n_err++; $display("FAIL rst_inflight got v=%b b=%b d=%b want 000", mem_valid, busy, done);
      end
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) dcnt++;
      end
      n_cmp++;
      if (dcnt !== 0) begin
         n_err++; $display("FAIL rst_quiet got %0d active cycles want 0", dcnt);
      end
      start(1'b0, 3'b010, 32'h700, 32'h0);
      n_cmp++;
      if ({mem_valid, mem_addr} !== {1'b1, 32'h700}) begin
         n_err++; $display("FAIL rst_after_issue got v=%b a=%h want v=1 a=00000700", mem_valid, mem_addr);
      end
      mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      mem_ready = 1'b0;
      n_cmp++;
      if ({done, fault, rdata} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
         n_err++; $display("FAIL rst_after_done got d=%b f=%b r=%h want d=1 f=0 r=a5a5a5a5",
                           done, fault, rdata);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_ext();
      test_store();
      test_decode_fault();
      test_timeout();
      test_back_to_back();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage that sits directly downstream of the multicycle control unit's memory states (MEMREAD/MEMWR). It takes a single load or store request (address from the ALU result register, store data from register B, width from funct3). It then runs one transaction on a valid/ready memory port with byte strobes and returns a sign- or zero-extended load result for the MEMWB write-back. Misaligned, illegal-width and timed-out accesses are reported as faults instead of reaching memory.

## Interface
- TIMEOUT, 255: maximum cycles `mem_valid` may wait for `mem_ready` before the transaction is aborted; 1..255.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  start request; sampled only in IDLE
- we  in  1  1 = store, 0 = load; sampled with req
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address; sampled with req
- wdata  in  32  store data, low-aligned; sampled with req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; transaction finished (success or fault)
- fault  out  1  valid with done; 1 = access rejected or aborted
- fault_code  out  2  valid with fault: 01 misaligned, 10 illegal funct3, 11 timeout
- rdata  out  32  extended load result; held from done until next accepted req
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_wstrb  out  4  byte write strobes; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid in the cycle mem_valid && mem_ready

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: when req=1, latch we/funct3/addr/wdata and check legality.
  - Legal: go to ACCESS.
  - Illegal: go to FAULT with the code below.
- Illegal funct3: loads 011/110/111; stores any funct3 other than 000/001/010.
- Illegal funct3 takes priority over misalignment.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- ACCESS: mem_valid=1 and mem_addr/mem_wstrb/mem_wdata driven from latched values, held stable until handshake.
  - On mem_valid && mem_ready: capture the read lane into rdata and go to DONE.
  - If the wait counter reaches TIMEOUT without ready: go to FAULT with code 11.
- DONE: done=1, fault=0; go to IDLE.
- FAULT: done=1, fault=1, fault_code held; rdata unchanged; no memory transaction issued for codes 01/10; go to IDLE.
- Store strobes:
  - B: 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - H: 0011<<addr[1:0], data {2{wdata[15:0]}}.
  - W: 1111, data wdata.
- Load extraction:
  - Byte lane addr[1:0], halfword lane addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - For stores rdata keeps its previous value.
- req while busy=1 is ignored; it is not queued.

## Timing
- Reset values:
  - State IDLE; busy, done, fault and mem_valid are 0.
  - fault_code is 00; mem_wstrb is 0000.
  - rdata, mem_addr and mem_wdata are 32'h0.
  - Wait counter is 0.
- All outputs are registered or decoded from the registered state; no combinational path from req/addr to mem_*.
- Legal access: req at cycle 0 → mem_valid from cycle 1; handshake at cycle 1+k (k≥0 wait cycles) → done at cycle 2+k; busy=0 and new req accepted at cycle 3+k.
- Fault at decode: req at cycle 0 → done+fault at cycle 1, IDLE at cycle 2; mem_valid never asserted.
- Timeout: the wait counter counts cycles with mem_valid=1 && mem_ready=0.
  - When the count equals TIMEOUT, go to FAULT on that edge; mem_valid drops the same cycle FAULT is entered.
  - A mem_ready in that same cycle takes priority: DONE, not FAULT.
- reset asserted in any state: next edge forces IDLE, mem_valid=0, no done pulse; the in-flight transaction is abandoned.

## Test plan
- LW from 0x100, mem_ready at first mem_valid cycle with mem_rdata=0xDEADBEEF → mem_addr=0x100, wstrb=0000, done at cycle 2, rdata=0xDEADBEEF, fault=0.
- LB at 0x103 with rdata 0x80FF1234 → rdata=0xFFFFFF80; LBU at the same address → 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB of wdata=0x000000AB to 0x0201 → mem_addr=0x200, wstrb=0010, mem_wdata=0xABABABAB; SH to 0x0202 → wstrb=1100.
- LW at 0x102 → done+fault at cycle 1, fault_code=01, mem_valid never high; store with funct3=100 → fault_code=10.
- TIMEOUT=4, mem_ready held 0 → mem_valid high for 4 cycles, then done+fault with fault_code=11; a follow-up req is accepted normally.
- Reset pulsed on the second wait cycle of a load → mem_valid=0 and busy=0 the next cycle, no done; req 5 cycles later completes normally.
